// File: rtl/carry_save_resolver.sv
// carry_save_resolver
// Resolves a carry-save pair (sum, carry<<1) into a plain binary result.
// The carry-propagate add is split into CHUNK_WIDTH-bit slices, one slice
// per clock, so the critical path is a single CHUNK_WIDTH-bit adder.
// Valid/ready handshakes on both sides; one operation in flight at a time.
//
// Optional feature macro: CARRY_SAVE_RESOLVER_OVF_EN
//   defined   -> overflow_o port present, flags results wider than BIT_WIDTH
//   undefined -> no overflow_o port and no overflow logic
module carry_save_resolver #(
    parameter int BIT_WIDTH   = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [BIT_WIDTH-1:0]   sum_i,
    input  logic [BIT_WIDTH-1:0]   carry_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [BIT_WIDTH+1:0]   result_o
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
    ,
    output logic                   overflow_o
`endif
);

    localparam int K     = BIT_WIDTH / CHUNK_WIDTH;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(K - 1);

    // A partial last slice would silently drop operand bits, so refuse it.
    generate
        if ((BIT_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk
            $error("carry_save_resolver: CHUNK_WIDTH must divide BIT_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One slice of the carry-propagate add: {carry_out, sum}.
    function automatic logic [CHUNK_WIDTH:0] add_chunk(
        input logic [CHUNK_WIDTH-1:0] a,
        input logic [CHUNK_WIDTH-1:0] b,
        input logic                   cin
    );
        return {1'b0, a} + {1'b0, b} + {{CHUNK_WIDTH{1'b0}}, cin};
    endfunction

    // Two top result bits: B[BIT_WIDTH] plus the final slice carry (max 2).
    function automatic logic [1:0] resolve_top(
        input logic b_msb,
        input logic cout
    );
        return {1'b0, b_msb} + {1'b0, cout};
    endfunction

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   cy_q;

    // Stage p0: captured operands. opa = sum, opb = carry pre-shifted by one.
    logic [BIT_WIDTH-1:0]   opa_p0;
    logic [BIT_WIDTH:0]     opb_p0;

    // Stage p1: slice-by-slice accumulator.
    logic [BIT_WIDTH-1:0]   acc_p1;

    // Stage p2: published result.
    logic [BIT_WIDTH+1:0]   result_p2;
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
    logic                   ovf_p2;
`endif

    logic [CHUNK_WIDTH-1:0] a_ch;
    logic [CHUNK_WIDTH-1:0] b_ch;
    logic [CHUNK_WIDTH:0]   ch_res;
    logic [BIT_WIDTH-1:0]   acc_nxt;
    logic [1:0]             top_bits;

    assign ready_o  = (state_q == ST_IDLE);
    assign valid_o  = (state_q == ST_DONE);
    assign result_o = result_p2;
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
    assign overflow_o = ovf_p2;
`endif

    // Select the current slice, add it, and merge it into the accumulator image.
    always_comb begin
        a_ch    = '0;
        b_ch    = '0;
        for (int k = 0; k < K; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                a_ch = opa_p0[k*CHUNK_WIDTH +: CHUNK_WIDTH];
                b_ch = opb_p0[k*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
        ch_res  = add_chunk(a_ch, b_ch, cy_q);
        acc_nxt = acc_p1;
        for (int k = 0; k < K; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                acc_nxt[k*CHUNK_WIDTH +: CHUNK_WIDTH] = ch_res[CHUNK_WIDTH-1:0];
            end
        end
        top_bits = resolve_top(opb_p0[BIT_WIDTH], ch_res[CHUNK_WIDTH]);
    end

    // Operand capture on the input handshake; operands need no reset since
    // the FSM never consumes them before a fresh capture.
    always_ff @(posedge clk_i) begin
        if (valid_i && ready_o) begin
            opa_p0 <= sum_i;
            opb_p0 <= {carry_i, 1'b0};
        end
    end

    // Control FSM: accept, resolve K slices, hold result until taken.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cy_q      <= 1'b0;
            acc_p1    <= '0;
            result_p2 <= '0;
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
            ovf_p2    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_i) begin
                        state_q <= ST_CALC;
                        cnt_q   <= '0;
                        cy_q    <= 1'b0;
                    end
                end
                ST_CALC: begin
                    acc_p1 <= acc_nxt;
                    cy_q   <= ch_res[CHUNK_WIDTH];
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CHUNK) begin
                        result_p2 <= {top_bits, acc_nxt};
`ifdef CARRY_SAVE_RESOLVER_OVF_EN
                        ovf_p2    <= |top_bits;
`endif
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/carry_save_resolver.md
# carry_save_resolver

Multi-cycle converter from carry-save (redundant) form back to plain binary: takes a sum vector and a carry vector as produced by the math/adder carry-save stage and resolves them into a single binary result. It is the final carry-propagate step after a CSA tree in multipliers and multi-operand accumulators. The ripple is split into CHUNK_WIDTH-bit slices, one slice per cycle, to keep the critical path short. Valid/ready handshakes are used on both input and output.

## Interface
- BIT_WIDTH, 32: width of the carry-save operands.
- CHUNK_WIDTH, 8: bits resolved per cycle; must divide BIT_WIDTH, otherwise elaboration fails. K = BIT_WIDTH/CHUNK_WIDTH.
- clk_i  input  1  clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  sum_i/carry_i valid.
- ready_o  output  1  block can accept an operand pair.
- sum_i  input  BIT_WIDTH  sum vector; bit i has weight 2^i.
- carry_i  input  BIT_WIDTH  carry vector; bit i has weight 2^(i+1).
- valid_o  output  1  result_o valid.
- ready_i  input  1  downstream accepts result.
- result_o  output  BIT_WIDTH+2  sum_i + (carry_i << 1), zero-extended, exact.
- overflow_o  output  1  present only with CARRY_SAVE_RESOLVER_OVF_EN.

## Operation
- Internal operands: A = {2'b0, sum_i}, B = {1'b0, carry_i, 1'b0}, latched on input handshake (valid_i && ready_o).
- States:
  - IDLE: ready_o=1. Handshake → CALC, chunk counter=0, chunk carry=0.
  - CALC: ready_o=0. Each cycle adds chunk j of A and B with the chunk carry, writes chunk j of the internal accumulator, and stores carry-out. On j=K-1, result bits [BIT_WIDTH+1:BIT_WIDTH] = B[BIT_WIDTH] + final carry-out; the full accumulator is copied to result_o; → DONE.
  - DONE: valid_o=1. Output handshake (valid_o && ready_i) → IDLE.
- result_o updates only on the CALC→DONE transition. It holds its value in DONE and after it, and is stable while valid_o=1.
- valid_i is ignored whenever ready_o=0. Inputs need not be held after the handshake.
- Reset: state=IDLE, ready_o=1, valid_o=0, result_o=0, overflow_o=0, counter/carry/accumulator=0. Reset in any state, including mid-CALC, discards the operation. rst_i has priority over every handshake.

## Timing
- The input handshake at edge E0 enters CALC. Chunks are resolved at edges E0+1 … E0+K. valid_o rises after edge E0+K (latency K cycles).
- With ready_i=1, the output handshake happens at E0+K+1 and the state returns to IDLE. The earliest next input handshake is at E0+K+2, giving a throughput of one operation per K+2 cycles.
- There are no combinational paths from inputs to outputs. ready_o and valid_o are decoded from registered state.

## Configuration
- CARRY_SAVE_RESOLVER_OVF_EN defined: overflow_o exists and equals |result_o[BIT_WIDTH+1:BIT_WIDTH]. It is registered together with result_o and follows the same reset value and hold rules. This flags results that do not fit in BIT_WIDTH bits.
- CARRY_SAVE_RESOLVER_OVF_EN undefined: the overflow_o port and its logic are absent. All other behaviour is identical.

## Test plan
- Defaults (K=4), sum_i=0x00000001, carry_i=0x00000001 → valid_o rises 4 cycles after the accept edge, result_o=0x3, overflow_o=0.
- sum_i=0xFFFFFFFF, carry_i=0x00000001 (full ripple across all chunks) → result_o=0x100000001, overflow_o=1.
- sum_i=0xFFFFFFFF, carry_i=0xFFFFFFFF → result_o=0x2FFFFFFFD, overflow_o=1.
- Backpressure: hold ready_i=0 for 5 cycles in DONE while pulsing valid_i with other data → result_o stable, ready_o=0, no second acceptance. After ready_i=1, IDLE is reached in 1 cycle.
- Assert rst_i during the 2nd CALC cycle → next cycle: valid_o=0, result_o=0, ready_o=1. A following op with sum_i=0x000000FF, carry_i=0x00000001 yields 0x101.
- CHUNK_WIDTH=32 (K=1), sum_i=0x80000000, carry_i=0x40000000 → result_o=0x100000000 after 1 cycle. Also check that CHUNK_WIDTH=7 with BIT_WIDTH=32 fails elaboration.
